// File: rtl/row_index_sequencer.sv
// Row-address sequencer: steps an offset through one quadrant, rewinds on new vectors,
// closes layers at the quadrant end and counts them with wrap or halt on the final layer.
module row_index_sequencer #(
    parameter int NUM_QUADS     = 2,
    parameter int ROWS_PER_QUAD = 6,
    parameter int ROWS_PER_VEC  = 2,
    parameter int NUM_LAYERS    = 3,
    parameter int WRAP_LAYERS   = 1,
    parameter int ROW_W         = 4,
    parameter int QSEL_W        = 1,
    parameter int LAYER_W       = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic               i_new_row,
    input  logic               i_new_vector,
    input  logic               i_new_quadrant_row,
    input  logic [QSEL_W-1:0]  i_quad_sel,
    output logic [ROW_W-1:0]   o_row_index,
    output logic [LAYER_W-1:0] o_layer_index,
    output logic               o_new_layer,
    output logic               o_done,
    output logic               o_seq_err
);
    localparam logic [ROW_W-1:0]   LP_LAST_OFF   = ROW_W'(ROWS_PER_QUAD - 1);
    localparam logic [ROW_W-1:0]   LP_REWIND     = ROW_W'(ROWS_PER_VEC);
    localparam logic [LAYER_W-1:0] LP_LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [31:0]        LP_NUM_QUADS  = 32'(NUM_QUADS);
    localparam logic [31:0]        LP_QUAD_ROWS  = 32'(ROWS_PER_QUAD);
    localparam logic               LP_WRAP       = (WRAP_LAYERS != 0);

    logic [ROW_W-1:0]   r_base;
    logic [ROW_W-1:0]   r_offset;
    logic [ROW_W-1:0]   r_row_index;
    logic [LAYER_W-1:0] r_layer;
    logic               r_done;
    logic               r_seq_err;
    logic               r_halted;

    logic [ROW_W-1:0]   w_base_d;
    logic [ROW_W-1:0]   w_offset_d;
    logic [ROW_W-1:0]   w_row_index_d;
    logic [LAYER_W-1:0] w_layer_d;
    logic               w_done_d;
    logic               w_seq_err_d;
    logic               w_halted_d;

    logic [31:0]        w_qsel_wide;
    logic               w_qsel_oor;
    logic [ROW_W-1:0]   w_qbase;
    logic               w_active;
    logic               w_new_layer;
    logic               w_restart;
    logic               w_increment;
    logic               w_last_layer;

    // Quadrant base from quad_sel; out-of-range selections fall back to quadrant 0.
    always_comb begin
        w_qsel_wide = 32'(i_quad_sel);
        w_qsel_oor  = (w_qsel_wide >= LP_NUM_QUADS);
        w_qbase     = w_qsel_oor ? '0 : ROW_W'(w_qsel_wide * LP_QUAD_ROWS);
    end

    always_comb begin
        w_active     = i_en & ~r_halted;
        w_new_layer  = w_active & i_new_quadrant_row & (r_offset == LP_LAST_OFF);
        w_restart    = w_active & i_new_vector & ~i_new_quadrant_row;
        w_increment  = w_active & (i_new_row | i_new_quadrant_row);
        w_last_layer = (r_layer == LP_LAST_LAYER);
    end

    always_comb begin
        w_base_d    = r_base;
        w_offset_d  = r_offset;
        w_layer_d   = r_layer;
        w_seq_err_d = r_seq_err;
        w_halted_d  = r_halted;
        // done is only sticky while halted; otherwise it is a one-cycle pulse
        w_done_d    = r_halted;

        if (i_clear) begin
            w_base_d    = w_qbase;
            w_offset_d  = '0;
            w_layer_d   = '0;
            w_done_d    = 1'b0;
            w_seq_err_d = w_qsel_oor;
            w_halted_d  = 1'b0;
        end else if (w_new_layer) begin
            w_base_d    = w_qbase;
            w_offset_d  = '0;
            w_seq_err_d = r_seq_err | w_qsel_oor;
            if (w_last_layer) begin
                w_done_d = 1'b1;
                if (LP_WRAP) begin
                    w_layer_d = '0;
                end else begin
                    w_halted_d = 1'b1;
                end
            end else begin
                w_layer_d = r_layer + LAYER_W'(1);
            end
        end else if (w_restart) begin
            if (r_offset < LP_REWIND) begin
                w_offset_d  = '0;
                w_seq_err_d = 1'b1;
            end else begin
                w_offset_d = r_offset - LP_REWIND;
            end
        end else if (w_increment) begin
            if (r_offset == LP_LAST_OFF) begin
                w_seq_err_d = 1'b1;
            end else begin
                w_offset_d = r_offset + ROW_W'(1);
            end
        end

        w_row_index_d = w_base_d + w_offset_d;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_base      <= '0;
            r_offset    <= '0;
            r_row_index <= '0;
            r_layer     <= '0;
            r_done      <= 1'b0;
            r_seq_err   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_base      <= w_base_d;
            r_offset    <= w_offset_d;
            r_row_index <= w_row_index_d;
            r_layer     <= w_layer_d;
            r_done      <= w_done_d;
            r_seq_err   <= w_seq_err_d;
            r_halted    <= w_halted_d;
        end
    end

    assign o_row_index   = r_row_index;
    assign o_layer_index = r_layer;
    assign o_new_layer   = w_new_layer;
    assign o_done        = r_done;
    assign o_seq_err     = r_seq_err;

endmodule

// File: tb/tb_row_index_sequencer.sv
// Bench for row_index_sequencer: a wrapping and a halting instance share stimulus and are
// compared every cycle against a behavioural model, plus hand-computed directed checks.
module tb_row_index_sequencer;
    localparam int NQ  = 2;
    localparam int RPQ = 6;
    localparam int RPV = 2;
    localparam int NL  = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic en = 1'b0;
    logic new_row = 1'b0;
    logic new_vector = 1'b0;
    logic new_qrow = 1'b0;
    logic [0:0] quad_sel = 1'b0;

    logic [3:0] row_w, row_h;
    logic [1:0] layer_w, layer_h;
    logic       nl_w, nl_h, done_w, done_h, err_w, err_h;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    row_index_sequencer #(
        .NUM_QUADS(NQ), .ROWS_PER_QUAD(RPQ), .ROWS_PER_VEC(RPV), .NUM_LAYERS(NL),
        .WRAP_LAYERS(1), .ROW_W(4), .QSEL_W(1), .LAYER_W(2)
    ) u_wrap (
        .i_clock(clock), .i_reset(reset), .i_clear(clear), .i_en(en),
        .i_new_row(new_row), .i_new_vector(new_vector), .i_new_quadrant_row(new_qrow),
        .i_quad_sel(quad_sel), .o_row_index(row_w), .o_layer_index(layer_w),
        .o_new_layer(nl_w), .o_done(done_w), .o_seq_err(err_w)
    );

    row_index_sequencer #(
        .NUM_QUADS(NQ), .ROWS_PER_QUAD(RPQ), .ROWS_PER_VEC(RPV), .NUM_LAYERS(NL),
        .WRAP_LAYERS(0), .ROW_W(4), .QSEL_W(1), .LAYER_W(2)
    ) u_halt (
        .i_clock(clock), .i_reset(reset), .i_clear(clear), .i_en(en),
        .i_new_row(new_row), .i_new_vector(new_vector), .i_new_quadrant_row(new_qrow),
        .i_quad_sel(quad_sel), .o_row_index(row_h), .o_layer_index(layer_h),
        .o_new_layer(nl_h), .o_done(done_h), .o_seq_err(err_h)
    );

    // Model: quadrant start row, position within quadrant, layer, flags.
    typedef struct {
        int qstart;
        int pos;
        int layer;
        bit done;
        bit err;
        bit halted;
    } mstate_t;

    mstate_t m_w, m_h;

    function automatic mstate_t m_reset();
        mstate_t s;
        s.qstart = 0; s.pos = 0; s.layer = 0; s.done = 0; s.err = 0; s.halted = 0;
        return s;
    endfunction

    function automatic bit m_closes(mstate_t s);
        return en && new_qrow && (s.pos == RPQ - 1) && !s.halted;
    endfunction

    function automatic mstate_t m_step(mstate_t s, bit wrap);
        mstate_t n = s;
        int qs = int'(quad_sel);
        int qstart = (qs < NQ) ? qs * RPQ : 0;
        bit oor = (qs >= NQ);
        n.done = s.halted;
        if (clear) begin
            n = m_reset();
            n.qstart = qstart;
            n.err = oor;
        end else if (!en || s.halted) begin
            // events ignored
        end else if (m_closes(s)) begin
            n.qstart = qstart;
            n.pos = 0;
            n.err = s.err | oor;
            if (s.layer == NL - 1) begin
                n.done = 1;
                if (wrap) n.layer = 0;
                else n.halted = 1;
            end else begin
                n.layer = s.layer + 1;
            end
        end else if (new_vector && !new_qrow) begin
            if (s.pos < RPV) begin n.pos = 0; n.err = 1; end
            else n.pos = s.pos - RPV;
        end else if (new_row || new_qrow) begin
            if (s.pos == RPQ - 1) n.err = 1;
            else n.pos = s.pos + 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        check("wrap.row", int'(row_w), m_w.qstart + m_w.pos);
        check("wrap.layer", int'(layer_w), m_w.layer);
        check("wrap.done", int'(done_w), int'(m_w.done));
        check("wrap.err", int'(err_w), int'(m_w.err));
        check("halt.row", int'(row_h), m_h.qstart + m_h.pos);
        check("halt.layer", int'(layer_h), m_h.layer);
        check("halt.done", int'(done_h), int'(m_h.done));
        check("halt.err", int'(err_h), int'(m_h.err));
    endtask

    // Apply one cycle of inputs; inputs move at posedge+1, comb checked at posedge+2.
    task automatic step(input bit c, input bit e, input bit nr, input bit nv, input bit nq,
                        input bit qs);
        clear = c; en = e; new_row = nr; new_vector = nv; new_qrow = nq; quad_sel = qs;
        #1;
        check("wrap.new_layer", int'(nl_w), int'(m_closes(m_w)));
        check("halt.new_layer", int'(nl_h), int'(m_closes(m_h)));
        @(posedge clock);
        m_w = m_step(m_w, 1'b1);
        m_h = m_step(m_h, 1'b0);
        #1;
        check_regs();
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, quad_sel);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        m_w = m_reset();
        m_h = m_reset();
        check_regs();
        #1 reset = 1'b0;
    endtask

    // Walk the wrapping instance to its quadrant end, then close the layer.
    task automatic close_layer(input bit qs);
        for (int k = 0; k < RPQ && m_w.pos != RPQ - 1; k++) step(0, 1, 1, 0, 0, qs);
        step(0, 1, 0, 0, 1, qs);
    endtask

    initial begin
        m_w = m_reset();
        m_h = m_reset();
        #12;
        check_regs();
        check("reset.row", int'(row_w), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Clear into quadrant 1 and walk to its last row
        step(1, 0, 0, 0, 0, 1);
        check("clear.row", int'(row_w), 6);
        for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 0, 1);
        check("walk.row", int'(row_w), 11);
        check("walk.err", int'(err_w), 0);

        // Layer close from row 11
        clear = 0; en = 1; new_row = 0; new_vector = 0; new_qrow = 1; quad_sel = 1;
        #1;
        check("close.new_layer", int'(nl_w), 1);
        step(0, 1, 0, 0, 1, 1);
        check("close.row", int'(row_w), 6);
        check("close.layer", int'(layer_w), 1);

        // Rewind and underflow in quadrant 0
        step(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        check("rewind.row", int'(row_w), 1);
        step(0, 1, 0, 1, 0, 0);
        check("underflow.row", int'(row_w), 0);
        check("underflow.err", int'(err_w), 1);
        step(0, 1, 0, 1, 1, 0);
        check("vec_qrow.row", int'(row_w), 1);

        // Three layer closes: wrap pulses done once, halt sticks
        step(1, 1, 0, 0, 0, 0);
        close_layer(0);
        check("layers.l1", int'(layer_w), 1);
        close_layer(0);
        check("layers.l2", int'(layer_w), 2);
        close_layer(0);
        check("layers.wrap", int'(layer_w), 0);
        check("layers.done", int'(done_w), 1);
        check("halt.layer2", int'(layer_h), 2);
        check("halt.done1", int'(done_h), 1);
        step(0, 1, 1, 0, 0, 0);
        check("layers.done_pulse", int'(done_w), 0);
        check("halt.ignored_row", int'(row_h), 0);
        check("halt.done_sticks", int'(done_h), 1);
        step(1, 1, 0, 0, 0, 0);
        check("halt.clear_done", int'(done_h), 0);
        check("halt.clear_layer", int'(layer_h), 0);

        // Overflow at quadrant 0 end, en=0 gating, clear with en=0
        for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        check("overflow.row", int'(row_w), 5);
        check("overflow.err", int'(err_w), 1);
        step(0, 0, 1, 0, 0, 0);
        check("en0.row", int'(row_w), 5);
        step(1, 0, 0, 0, 0, 0);
        check("en0_clear.row", int'(row_w), 0);
        check("en0_clear.err", int'(err_w), 0);

        // Async reset mid-pass at row 9, layer 1
        step(1, 1, 0, 0, 0, 1);
        close_layer(1);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 1);
        check("pre_reset.row", int'(row_w), 9);
        check("pre_reset.layer", int'(layer_w), 1);
        async_reset();
        check("async.row", int'(row_w), 0);
        check("async.layer", int'(layer_w), 0);

        // Randomised phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 30), 1'($urandom_range(0, 1)));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
